// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit bounds and the load-sanitising helper.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic bcd_digit_t bcd_sanitise(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MIN : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the up/down counter; steps when every lower digit is terminal.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       step,
  input  logic       up,
  output bcd_digit_t q,
  output logic       last
);

  logic at_top;
  logic at_bottom;

  // Illegal codes sit at both ends so the digit self-corrects on its next step.
  assign at_top    = (q >= BCD_MAX);
  assign at_bottom = (q == BCD_MIN) || (q > BCD_MAX);
  assign last      = up ? at_top : at_bottom;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= BCD_MIN;
    end else if (clr) begin
      q <= BCD_MIN;
    end else if (load) begin
      q <= bcd_sanitise(load_digit);
    end else if (step) begin
      if (up) q <= at_top    ? BCD_MIN : q + 4'd1;
      else    q <= at_bottom ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with clear, sanitised load, cascade tc and wrap pulse.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] last;
  logic [DIGITS-1:0] bad;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign step[i] = en;
    end else begin : g_upper
      assign step[i] = en & (&last[i-1:0]);
    end

    assign bad[i] = (load_val[4*i +: 4] > BCD_MAX);

    bcd_digit u_digit (
      .clk        (clk),
      .reset_n    (reset_n),
      .clr        (clr),
      .load       (load),
      .load_digit (load_val[4*i +: 4]),
      .step       (step[i]),
      .up         (up),
      .q          (count[4*i +: 4]),
      .last       (last[i])
    );
  end

  assign tc = step[DIGITS-1] & last[DIGITS-1] & ~clr & ~load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= tc;
      load_err <= ~clr & load & (|bad);
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed plus random checks of bcd_counter_n against an integer decimal model,
// with a two-instance DIGITS=2 cascade running in lockstep with the DIGITS=4 instance.
module tb_bcd_counter_n;

  localparam int MOD = 10000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clr, load, en, up;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        tc, wrap, load_err;

  logic [7:0]  lo_count, hi_count;
  logic        lo_tc, hi_tc, lo_wrap, hi_wrap, lo_lerr, hi_lerr;

  int checks = 0;
  int errors = 0;

  int   m_val;
  logic m_wrap, m_lerr;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(4)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(count), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  bcd_counter_n #(.DIGITS(2)) u_lo (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val[7:0]),
    .en(en), .up(up), .count(lo_count), .tc(lo_tc), .wrap(lo_wrap), .load_err(lo_lerr)
  );

  bcd_counter_n #(.DIGITS(2)) u_hi (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val[15:8]),
    .en(lo_tc), .up(up), .count(hi_count), .tc(hi_tc), .wrap(hi_wrap), .load_err(hi_lerr)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic c, input logic l, input logic [15:0] lv,
                            input logic e, input logic u);
    logic [15:0] v;
    int d, p;
    m_wrap = 1'b0;
    m_lerr = 1'b0;
    if (c) begin
      m_val = 0;
    end else if (l) begin
      v = lv;
      m_val = 0;
      p = 1;
      for (int i = 0; i < 4; i++) begin
        d = int'(v[4*i +: 4]);
        if (d > 9) begin
          d = 0;
          m_lerr = 1'b1;
        end
        m_val += d * p;
        p *= 10;
      end
    end else if (e) begin
      if (u) begin
        m_wrap = (m_val == MOD - 1);
        m_val  = (m_val + 1) % MOD;
      end else begin
        m_wrap = (m_val == 0);
        m_val  = (m_val + MOD - 1) % MOD;
      end
    end
  endtask

  task automatic cyc(input logic c, input logic l, input logic [15:0] lv,
                     input logic e, input logic u);
    logic exp_tc;
    clr = c; load = l; load_val = lv; en = e; up = u;
    #1;
    exp_tc = e & ~c & ~l & (u ? (m_val == MOD - 1) : (m_val == 0));
    check("tc", 32'(tc), 32'(exp_tc));
    check("cascade_tc", 32'(hi_tc), 32'(exp_tc));
    @(posedge clk);
    model_edge(c, l, lv, e, u);
    #1;
    check("count", 32'(count), 32'(to_bcd(m_val)));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("load_err", 32'(load_err), 32'(m_lerr));
    check("cascade_count", 32'({hi_count, lo_count}), 32'(to_bcd(m_val)));
    check("cascade_wrap", 32'(hi_wrap), 32'(m_wrap));
  endtask

  initial begin
    reset_n = 1'b0;
    clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b1;
    m_val = 0; m_wrap = 1'b0; m_lerr = 1'b0;
    #22;
    check("reset_count", 32'(count), 32'h0);
    check("reset_wrap", 32'(wrap), 32'h0);
    check("reset_load_err", 32'(load_err), 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // asynchronous reset mid-count
    cyc(0, 1, 16'h0456, 0, 1);
    cyc(0, 0, 16'h0000, 1, 1);
    #3;
    reset_n = 1'b0;
    #1;
    m_val = 0; m_wrap = 1'b0; m_lerr = 1'b0;
    check("async_reset_count", 32'(count), 32'h0);
    check("async_reset_wrap", 32'(wrap), 32'h0);
    check("async_reset_load_err", 32'(load_err), 32'h0);
    #2;
    reset_n = 1'b1;
    cyc(0, 0, 16'h0000, 1, 1);

    // up carry chain and wrap
    cyc(0, 1, 16'h0999, 0, 1);
    cyc(0, 0, 16'h0000, 1, 1);
    cyc(0, 1, 16'h9998, 0, 1);
    cyc(0, 0, 16'h0000, 1, 1);
    cyc(0, 0, 16'h0000, 1, 1);
    cyc(0, 0, 16'h0000, 0, 1);

    // down borrow and wrap
    cyc(0, 1, 16'h1000, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0);
    cyc(1, 0, 16'h0000, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0);
    cyc(0, 0, 16'h0000, 0, 0);

    // sanitised and clean loads
    cyc(0, 1, 16'h3A7F, 1, 1);
    cyc(0, 1, 16'h1234, 1, 1);
    cyc(0, 0, 16'h0000, 0, 1);

    // priority clr > load > en
    cyc(0, 1, 16'h9999, 0, 1);
    cyc(1, 1, 16'h5555, 1, 1);
    cyc(0, 1, 16'h5555, 1, 1);

    // cascade crossing and hold
    cyc(0, 1, 16'h0098, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0000, 1, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 16'h0000, 0, 1);

    // randomized traffic, biased towards counting with occasional control events
    for (int i = 0; i < 400; i++) begin
      logic c, l, e, u;
      logic [15:0] lv;
      c  = ($urandom_range(0, 31) == 0);
      l  = ($urandom_range(0, 11) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = ($urandom_range(0, 3) != 0) ^ (i >= 200);
      lv = ($urandom_range(0, 2) == 0) ? 16'($urandom) :
           (($urandom_range(0, 1) == 0) ? 16'h9998 : 16'h0001);
      cyc(c, l, lv, e, u);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
- Parametrised multi-digit BCD counter, successor to the single-digit 0-9 counter.
- Adds:
  - DIGITS-wide decimal counting.
  - Up/down mode.
  - Count enable.
  - Synchronous clear.
  - Parallel load with digit sanitising.
  - Terminal-count output for cascading, plus a registered wrap pulse.
- Used as a timebase, event tally and display counter; instances chain via tc into the next instance's en.

Parameters:
- DIGITS, 4, number of BCD digits (legal range 1..8); count width is 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear, highest priority
- load  input  1  synchronous parallel load
- load_val  input  4*DIGITS  load value, digit i in bits [4i+3:4i]
- en  input  1  count enable
- up  input  1  1 = increment, 0 = decrement
- count  output  4*DIGITS  registered BCD count, digit 0 = least significant
- tc  output  1  combinational terminal count
- wrap  output  1  registered one-cycle wrap pulse
- load_err  output  1  registered one-cycle pulse on a sanitised load

Behaviour:
- Reset: reset_n low asynchronously forces count=0, wrap=0, load_err=0. Release is synchronous to the next clk edge; no state change on the release edge beyond normal operation.
- Per-edge priority is clr > load > en. wrap and load_err are 0 on any edge that does not set them.
- clr=1:
  - count<=0, wrap<=0, load_err<=0.
  - load and en are ignored.
- load=1 (clr=0):
  - Each digit of load_val in 0..9 is taken as-is.
  - Any digit in A..F is loaded as 0, and load_err<=1 for one cycle.
  - en is ignored; wrap<=0.
- en=1, up=1:
  - Decimal increment with ripple carry; digit 9 -> 0 carries into the next digit.
  - All-nines -> all-zeros, with wrap<=1 on the same edge.
- en=1, up=0:
  - Decimal decrement with borrow; digit 0 -> 9 borrows from the next digit.
  - All-zeros -> all-nines, with wrap<=1 on the same edge.
- en=0: count holds.
- Latency:
  - count changes on the edge where the command is sampled.
  - wrap and load_err are high exactly during the cycle following that edge.
- tc = en & ~clr & ~load & (up ? every digit==9 : every digit==0).
  - Purely combinational; no register.
  - Intended to drive a downstream instance's en.
  - Asserted in the cycle before the edge that wraps.
- up may change every cycle; direction is sampled per edge with no turnaround cycle.
- Illegal digit codes (A..F) are unreachable via the ports. If one is present (e.g. a forced value):
  - On increment it is treated as 9: it becomes 0 and carries.
  - On decrement it is treated as 0: it becomes 9 and borrows.
  - The counter therefore self-corrects within one enabled edge.
- DIGITS=1 reduces to a 0-9 up/down counter with the same wrap/tc semantics.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_MAX=4'd9 and BCD_MIN=4'd0.
  - Digit typedef bcd_digit_t (4 bits).
  - Function bcd_sanitise(digit), which returns 0 for A..F.
- One sub-module, bcd_digit:
  - Ports: clk, reset_n, clr, load, load_digit, step, up, q, last.
  - last = (up ? q==9 : q==0), with illegal codes counted as terminal.
  - The parent generates DIGITS instances.
  - step for digit i = en & AND of last for digits 0..i-1.
  - tc and wrap derive from step & last of the top digit.
- The top level holds the wrap and load_err registers and the tc logic.

Test Plan:
- Reset: reset_n low mid-count at 0x0457, asynchronously between edges -> count=0x0000, wrap=0, load_err=0 immediately. First enabled up edge after release -> 0x0001.
- Up carry chain: load 0x0999, en=1, up=1 -> 0x1000 after one edge, wrap=0. Load 0x9998 -> 0x9999 with tc=1 -> next edge 0x0000 with wrap=1 for exactly one cycle.
- Down borrow: load 0x1000, up=0, en=1 -> 0x0999. From 0x0000, tc=1 -> next edge 0x9999 with wrap=1 for one cycle.
- Sanitised load: load_val=0x3A7F -> count=0x3070, load_err=1 for one cycle. load_val=0x1234 -> count=0x1234, load_err=0.
- Priority/simultaneous: at 0x9999 with clr=1, load=1 (0x5555), en=1, up=1 -> 0x0000, wrap=0. Next with clr=0, load=1, en=1 -> 0x5555, no increment, wrap=0.
- Cascade and hold: two DIGITS=2 instances, low.tc -> high.en. Counting up from 0x0098 across 3 edges -> 0x0099, 0x0100, 0x0101, matching a single DIGITS=4 instance. en=0 for 5 edges -> count unchanged, tc=0.
